// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings,
// the default reset PC and the sequential PC increment.
package if_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_KILL = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // Wraps silently at 2^32; no alignment handling on purpose.
    function automatic logic [31:0] pc_plus_step(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: single-outstanding Icache request, redirect handling
// and kill of in-flight fetches made stale by a jump or taken branch.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fc_stall_if_i,
    input  logic        id_jump_flag_i,
    input  logic [31:0] id_jump_pc_i,
    input  logic        ex_branch_flag_i,
    input  logic [31:0] ex_branch_pc_i,
    input  logic        Icache_ready_i,
    output logic        if_req_o,
    output logic [31:0] if_addr_o,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  npc_reg, npc_next;
    logic [31:0]  req_pc_reg, req_pc_next;

    logic         redirect;
    logic [31:0]  target;
    logic [31:0]  fetch_addr;
    logic         issue;

    // EX is older in program order, so its branch overrides an ID jump.
    assign redirect   = ex_branch_flag_i | id_jump_flag_i;
    assign target     = ex_branch_flag_i ? ex_branch_pc_i : id_jump_pc_i;
    assign fetch_addr = redirect ? target : npc_reg;

    always_comb begin
        issue = 1'b0;
        if (!fc_stall_if_i) begin
            unique case (state_reg)
                ST_IDLE: issue = 1'b1;
                ST_WAIT: issue = Icache_ready_i;
                ST_KILL: issue = Icache_ready_i;
                default: issue = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            npc_reg    <= RESET_PC;
            req_pc_reg <= RESET_PC;
        end else begin
            state_reg  <= state_next;
            npc_reg    <= npc_next;
            req_pc_reg <= req_pc_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        req_pc_next = req_pc_reg;
        npc_next    = npc_reg;
        if (issue) begin
            state_next  = ST_WAIT;
            req_pc_next = fetch_addr;
            npc_next    = pc_plus_step(fetch_addr);
        end else begin
            // Any redirect not consumed by an issue is remembered in npc.
            if (redirect)
                npc_next = target;
            unique case (state_reg)
                ST_IDLE: state_next = ST_IDLE;
                ST_WAIT: begin
                    if (Icache_ready_i)
                        state_next = ST_IDLE;
                    else if (redirect)
                        state_next = ST_KILL;
                end
                ST_KILL: begin
                    if (Icache_ready_i)
                        state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        if_req_o   = issue;
        if_addr_o  = fetch_addr;
        if_valid_o = (state_reg == ST_WAIT) && Icache_ready_i && !redirect;
        if_pc_o    = req_pc_reg;
    end

endmodule

// File: tb/tb_if_fetch.sv
// Scenario bench for if_fetch: expected returned PCs are queued when the
// request is issued and popped when the DUT presents a live instruction.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fc_stall_if_i;
    logic        id_jump_flag_i;
    logic [31:0] id_jump_pc_i;
    logic        ex_branch_flag_i;
    logic [31:0] ex_branch_pc_i;
    logic        Icache_ready_i;
    logic        if_req_o;
    logic [31:0] if_addr_o;
    logic        if_valid_o;
    logic [31:0] if_pc_o;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_pc;

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fc_stall_if_i   (fc_stall_if_i),
        .id_jump_flag_i  (id_jump_flag_i),
        .id_jump_pc_i    (id_jump_pc_i),
        .ex_branch_flag_i(ex_branch_flag_i),
        .ex_branch_pc_i  (ex_branch_pc_i),
        .Icache_ready_i  (Icache_ready_i),
        .if_req_o        (if_req_o),
        .if_addr_o       (if_addr_o),
        .if_valid_o      (if_valid_o),
        .if_pc_o         (if_pc_o)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic drive(input logic stall, input logic jf, input logic [31:0] jpc,
                         input logic bf, input logic [31:0] bpc, input logic rdy);
        fc_stall_if_i    = stall;
        id_jump_flag_i   = jf;
        id_jump_pc_i     = jpc;
        ex_branch_flag_i = bf;
        ex_branch_pc_i   = bpc;
        Icache_ready_i   = rdy;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (if_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid got=%b want=0", if_valid_o);
        end
        vectors++;
        if (if_pc_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_pc got=%h want=00000000", if_pc_o);
        end
        $display("reset: valid=%b pc=%h", if_valid_o, if_pc_o);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if (if_req_o !== 1'b1 || if_addr_o !== 32'h0) begin
            miscompares++;
            $display("FAIL b2b_first_req got req=%b addr=%h want req=1 addr=00000000", if_req_o, if_addr_o);
        end
        sb.push_back(32'h0);
        $display("b2b: req addr=%h", if_addr_o);
        tick();
        for (int k = 1; k <= 3; k++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            exp_pc = sb.pop_front();
            vectors++;
            if (if_valid_o !== 1'b1 || if_pc_o !== exp_pc) begin
                miscompares++;
                $display("FAIL b2b_resp got valid=%b pc=%h want valid=1 pc=%h", if_valid_o, if_pc_o, exp_pc);
            end
            vectors++;
            if (if_req_o !== 1'b1 || if_addr_o !== 32'(4 * k)) begin
                miscompares++;
                $display("FAIL b2b_req got req=%b addr=%h want req=1 addr=%h", if_req_o, if_addr_o, 32'(4 * k));
            end
            sb.push_back(32'(4 * k));
            $display("b2b: resp pc=%h valid=%b, req addr=%h", if_pc_o, if_valid_o, if_addr_o);
            tick();
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        exp_pc = sb.pop_front();
        vectors++;
        if (if_valid_o !== 1'b1 || if_pc_o !== exp_pc || if_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_stall_resp got valid=%b pc=%h req=%b want valid=1 pc=%h req=0",
                     if_valid_o, if_pc_o, if_req_o, exp_pc);
        end
        $display("b2b: stalled resp pc=%h", if_pc_o);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if (if_req_o !== 1'b0 || if_valid_o !== 1'b0 || if_addr_o !== 32'h10) begin
            miscompares++;
            $display("FAIL b2b_idle got req=%b valid=%b addr=%h want req=0 valid=0 addr=00000010",
                     if_req_o, if_valid_o, if_addr_o);
        end
        $display("b2b: idle stalled, npc=%h", if_addr_o);
        tick();
    endtask

    task automatic test_kill();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if (if_req_o !== 1'b1 || if_addr_o !== 32'h10) begin
            miscompares++;
            $display("FAIL kill_req got req=%b addr=%h want req=1 addr=00000010", if_req_o, if_addr_o);
        end
        tick();
        drive(1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
        vectors++;
        if (if_req_o !== 1'b0 || if_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL kill_jump got req=%b valid=%b want req=0 valid=0", if_req_o, if_valid_o);
        end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (if_valid_o !== 1'b0 || if_req_o !== 1'b1 || if_addr_o !== 32'h200) begin
            miscompares++;
            $display("FAIL kill_drop got valid=%b req=%b addr=%h want valid=0 req=1 addr=00000200",
                     if_valid_o, if_req_o, if_addr_o);
        end
        sb.push_back(32'h200);
        $display("kill: stale resp dropped valid=%b, req addr=%h", if_valid_o, if_addr_o);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        exp_pc = sb.pop_front();
        vectors++;
        if (if_valid_o !== 1'b1 || if_pc_o !== exp_pc) begin
            miscompares++;
            $display("FAIL kill_target_resp got valid=%b pc=%h want valid=1 pc=%h", if_valid_o, if_pc_o, exp_pc);
        end
        $display("kill: resp pc=%h valid=%b", if_pc_o, if_valid_o);
        tick();
    endtask

    task automatic test_priority();
        drive(1'b0, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0);
        vectors++;
        if (if_req_o !== 1'b1 || if_addr_o !== 32'h80) begin
            miscompares++;
            $display("FAIL prio_ex_wins got req=%b addr=%h want req=1 addr=00000080", if_req_o, if_addr_o);
        end
        $display("prio: req addr=%h", if_addr_o);
        tick();
        drive(1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (if_valid_o !== 1'b0 || if_req_o !== 1'b1 || if_addr_o !== 32'h300) begin
            miscompares++;
            $display("FAIL prio_same_cycle_drop got valid=%b req=%b addr=%h want valid=0 req=1 addr=00000300",
                     if_valid_o, if_req_o, if_addr_o);
        end
        sb.push_back(32'h300);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        exp_pc = sb.pop_front();
        vectors++;
        if (if_valid_o !== 1'b1 || if_pc_o !== exp_pc) begin
            miscompares++;
            $display("FAIL prio_resp got valid=%b pc=%h want valid=1 pc=%h", if_valid_o, if_pc_o, exp_pc);
        end
        $display("prio: resp pc=%h valid=%b", if_pc_o, if_valid_o);
        tick();
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b1, 32'h20, 1'b0, 32'h0, 1'b0);
        vectors++;
        if (if_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_idle_redirect got req=%b want 0", if_req_o);
        end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if (if_req_o !== 1'b1 || if_addr_o !== 32'h20) begin
            miscompares++;
            $display("FAIL stall_req got req=%b addr=%h want req=1 addr=00000020", if_req_o, if_addr_o);
        end
        sb.push_back(32'h20);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        exp_pc = sb.pop_front();
        vectors++;
        if (if_valid_o !== 1'b1 || if_pc_o !== exp_pc || if_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_resp got valid=%b pc=%h req=%b want valid=1 pc=%h req=0",
                     if_valid_o, if_pc_o, if_req_o, exp_pc);
        end
        $display("stall: resp pc=%h valid=%b req=%b", if_pc_o, if_valid_o, if_req_o);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (if_valid_o !== 1'b0 || if_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_idle_ready got valid=%b req=%b want valid=0 req=0", if_valid_o, if_req_o);
        end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if (if_req_o !== 1'b1 || if_addr_o !== 32'h24) begin
            miscompares++;
            $display("FAIL stall_release_req got req=%b addr=%h want req=1 addr=00000024", if_req_o, if_addr_o);
        end
        sb.push_back(32'h24);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if (if_req_o !== 1'b0 || if_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_wait_hold got req=%b valid=%b want req=0 valid=0", if_req_o, if_valid_o);
        end
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        exp_pc = sb.pop_front();
        vectors++;
        if (if_valid_o !== 1'b1 || if_pc_o !== exp_pc) begin
            miscompares++;
            $display("FAIL stall_resp2 got valid=%b pc=%h want valid=1 pc=%h", if_valid_o, if_pc_o, exp_pc);
        end
        $display("stall: resp pc=%h valid=%b", if_pc_o, if_valid_o);
        tick();
    endtask

    task automatic test_wrap();
        drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if (if_req_o !== 1'b1 || if_addr_o !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL wrap_req got req=%b addr=%h want req=1 addr=fffffffc", if_req_o, if_addr_o);
        end
        sb.push_back(32'hFFFF_FFFC);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        exp_pc = sb.pop_front();
        vectors++;
        if (if_valid_o !== 1'b1 || if_pc_o !== exp_pc) begin
            miscompares++;
            $display("FAIL wrap_resp got valid=%b pc=%h want valid=1 pc=%h", if_valid_o, if_pc_o, exp_pc);
        end
        vectors++;
        if (if_req_o !== 1'b1 || if_addr_o !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_next_addr got req=%b addr=%h want req=1 addr=00000000", if_req_o, if_addr_o);
        end
        sb.push_back(32'h0);
        $display("wrap: resp pc=%h, next req addr=%h", if_pc_o, if_addr_o);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        exp_pc = sb.pop_front();
        vectors++;
        if (if_valid_o !== 1'b1 || if_pc_o !== exp_pc) begin
            miscompares++;
            $display("FAIL wrap_resp0 got valid=%b pc=%h want valid=1 pc=%h", if_valid_o, if_pc_o, exp_pc);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        vectors++;
        if (if_req_o !== 1'b1 || if_addr_o !== 32'h40) begin
            miscompares++;
            $display("FAIL rstmid_req got req=%b addr=%h want req=1 addr=00000040", if_req_o, if_addr_o);
        end
        tick();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        sb.delete();
        vectors++;
        if (if_valid_o !== 1'b0 || if_pc_o !== 32'h0) begin
            miscompares++;
            $display("FAIL rstmid_in_reset got valid=%b pc=%h want valid=0 pc=00000000", if_valid_o, if_pc_o);
        end
        tick();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (if_valid_o !== 1'b0 || if_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_late_ready got valid=%b req=%b want valid=0 req=0", if_valid_o, if_req_o);
        end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if (if_req_o !== 1'b1 || if_addr_o !== 32'h0) begin
            miscompares++;
            $display("FAIL rstmid_first_req got req=%b addr=%h want req=1 addr=00000000", if_req_o, if_addr_o);
        end
        sb.push_back(32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        exp_pc = sb.pop_front();
        vectors++;
        if (if_valid_o !== 1'b1 || if_pc_o !== exp_pc) begin
            miscompares++;
            $display("FAIL rstmid_resp got valid=%b pc=%h want valid=1 pc=%h", if_valid_o, if_pc_o, exp_pc);
        end
        $display("rstmid: resp pc=%h valid=%b", if_pc_o, if_valid_o);
        tick();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got=%0d entries want=0", sb.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        fc_stall_if_i = 1'b0;
        id_jump_flag_i = 1'b0;
        id_jump_pc_i = 32'h0;
        ex_branch_flag_i = 1'b0;
        ex_branch_pc_i = 32'h0;
        Icache_ready_i = 1'b0;
        tick();
        test_reset();
        test_back_to_back();
        test_kill();
        test_priority();
        test_stall();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
